cmd_queue: RTL and testbench

Command FIFO sitting directly upstream of the command issuer. It buffers commands pushed by the host/loader and commands re-queued by the issuer when the scoreboard reports a dependency. It presents the oldest command first-word-fall-through on the issuer's read port. Requeue writes take priority over host writes, so a stalled command is never lost while the queue has room.

---
 rtl/cmd_queue.sv | 86 ++++++++
 tb/tb_cmd_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_queue.sv
// Command FIFO feeding the command issuer: host pushes plus issuer requeues,
// requeue has write priority, head presented first-word-fall-through.
module cmd_queue #(
  parameter int DEPTH = 16,
  parameter int CMD_W = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_host_write,
  input  logic [CMD_W-1:0]         i_host_cmd,
  output logic                     o_host_ready,
  input  logic                     i_write,
  input  logic [CMD_W-1:0]         i_cmd,
  input  logic                     i_read,
  output logic [CMD_W-1:0]         o_cmd,
  output logic                     o_valid,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             unf;

  logic             empty;
  logic             rd;
  logic             space;
  logic             host_ready;
  logic             wr;
  logic [CMD_W-1:0] wdata;

  // A full queue still has room when the head leaves in the same cycle.
  always_comb begin
    empty      = (cnt == '0);
    rd         = i_read && !empty;
    space      = (cnt != FULL_CNT) || rd;
    host_ready = !i_write && space && !i_flush;
    wr         = !i_flush && ((i_write && space) || (!i_write && i_host_write && host_ready));
    wdata      = i_write ? i_cmd : i_host_cmd;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (i_flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      if (wr && !rd)      cnt <= cnt + 1'b1;
      else if (!wr && rd) cnt <= cnt - 1'b1;
      if (i_write && !space) ovf <= 1'b1;
      if (i_read && empty)   unf <= 1'b1;
    end
  end

  // Storage is data only; it is neither reset nor cleared by flush.
  always_ff @(posedge i_clk) begin
    if (wr) mem[wp] <= wdata;
  end

  assign o_cmd        = mem[rp];
  assign o_valid      = !empty;
  assign o_count      = cnt;
  assign o_overflow   = ovf;
  assign o_underflow  = unf;
  assign o_host_ready = host_ready;

endmodule

// File: tb/tb_cmd_queue.sv
// Randomised bench for cmd_queue against a queue-based reference model.
module tb_cmd_queue;

  localparam int DEPTH = 16;
  localparam int CMD_W = 64;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_host_write = 1'b0;
  logic [CMD_W-1:0] i_host_cmd = '0;
  logic             o_host_ready;
  logic             i_write = 1'b0;
  logic [CMD_W-1:0] i_cmd = '0;
  logic             i_read = 1'b0;
  logic [CMD_W-1:0] o_cmd;
  logic             o_valid;
  logic             i_flush = 1'b0;
  logic [4:0]       o_count;
  logic             o_overflow;
  logic             o_underflow;

  cmd_queue #(.DEPTH(DEPTH), .CMD_W(CMD_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_host_write(i_host_write), .i_host_cmd(i_host_cmd), .o_host_ready(o_host_ready),
    .i_write(i_write), .i_cmd(i_cmd), .i_read(i_read),
    .o_cmd(o_cmd), .o_valid(o_valid), .i_flush(i_flush),
    .o_count(o_count), .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [CMD_W-1:0] q[$];
  bit               m_ovf = 0;
  bit               m_unf = 0;
  logic             rdy_seen;
  logic             rdy_exp;

  function automatic logic [CMD_W-1:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  task automatic model_step(input bit w, input logic [CMD_W-1:0] wc, input bit hw,
                            input logic [CMD_W-1:0] hc, input bit rd, input bit fl);
    bit rd_eff, room;
    rd_eff = rd && q.size() != 0;
    room   = q.size() < DEPTH || rd_eff;
    if (fl) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (rd && q.size() == 0) m_unf = 1;
      if (rd_eff) void'(q.pop_front());
      if (w) begin
        if (room) q.push_back(wc);
        else      m_ovf = 1;
      end else if (hw && room) begin
        q.push_back(hc);
      end
    end
  endtask

  // One clock cycle: drive, sample ready, clock, update model, idle inputs.
  task automatic cycle(input bit w, input logic [CMD_W-1:0] wc, input bit hw,
                       input logic [CMD_W-1:0] hc, input bit rd, input bit fl);
    i_write = w; i_cmd = wc; i_host_write = hw; i_host_cmd = hc; i_read = rd; i_flush = fl;
    #1;
    rdy_seen = o_host_ready;
    rdy_exp  = !w && !fl && (q.size() < DEPTH || (rd && q.size() != 0));
    @(posedge i_clk);
    model_step(w, wc, hw, hc, rd, fl);
    @(negedge i_clk);
    i_write = 0; i_host_write = 0; i_read = 0; i_flush = 0;
  endtask

  task automatic test_reset();
    i_rst = 1;
    repeat (2) @(negedge i_clk);
    i_write = 1;
    #1;
    checks++;
    if (o_host_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_w1 got %0b want 0", o_host_ready);
    end
    i_write = 0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_count !== 5'd0 || o_overflow !== 1'b0 ||
        o_underflow !== 1'b0 || o_host_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got v=%0b c=%0d ov=%0b un=%0b rdy=%0b want 0 0 0 0 1",
               o_valid, o_count, o_overflow, o_underflow, o_host_ready);
    end
    @(negedge i_clk);
    i_rst = 0;
    q.delete(); m_ovf = 0; m_unf = 0;
  endtask

  task automatic test_basic();
    logic [CMD_W-1:0] w[3];
    for (int i = 0; i < 3; i++) w[i] = rnd_word();
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, w[i], 0, 0);
    checks++;
    if (o_count !== 5'd3 || o_cmd !== w[0]) begin
      errors++; $display("FAIL basic_fill got c=%0d cmd=%h want 3 %h", o_count, o_cmd, w[0]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_cmd !== w[i]) begin
        errors++; $display("FAIL basic_pop%0d got v=%0b cmd=%h want 1 %h", i, o_valid, o_cmd, w[i]);
      end
      cycle(0, '0, 0, '0, 1, 0);
    end
    checks++;
    if (o_valid !== 1'b0 || o_count !== 5'd0) begin
      errors++; $display("FAIL basic_empty got v=%0b c=%0d want 0 0", o_valid, o_count);
    end
  endtask

  task automatic test_requeue_priority();
    logic [CMD_W-1:0] exp[4];
    for (int i = 0; i < 4; i++) exp[i] = rnd_word();
    cycle(0, '0, 1, exp[0], 0, 0);
    cycle(0, '0, 1, exp[1], 0, 0);
    cycle(1, exp[2], 1, exp[3], 0, 0);
    checks++;
    if (rdy_seen !== 1'b0 || o_count !== 5'd3) begin
      errors++; $display("FAIL prio_block got rdy=%0b c=%0d want 0 3", rdy_seen, o_count);
    end
    cycle(0, '0, 1, exp[3], 0, 0);
    checks++;
    if (rdy_seen !== 1'b1 || o_count !== 5'd4) begin
      errors++; $display("FAIL prio_host got rdy=%0b c=%0d want 1 4", rdy_seen, o_count);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_cmd !== exp[i]) begin
        errors++; $display("FAIL prio_order%0d got %h want %h", i, o_cmd, exp[i]);
      end
      cycle(0, '0, 0, '0, 1, 0);
    end
  endtask

  task automatic test_full();
    logic [CMD_W-1:0] r1, r2;
    for (int i = 0; i < DEPTH; i++) cycle(0, '0, 1, rnd_word(), 0, 0);
    checks++;
    if (o_count !== 5'd16 || o_host_ready !== 1'b0) begin
      errors++; $display("FAIL full_fill got c=%0d rdy=%0b want 16 0", o_count, o_host_ready);
    end
    r1 = rnd_word();
    cycle(1, r1, 0, '0, 0, 0);
    checks++;
    if (o_overflow !== 1'b1 || o_count !== 5'd16) begin
      errors++; $display("FAIL full_overflow got ov=%0b c=%0d want 1 16", o_overflow, o_count);
    end
    r2 = rnd_word();
    cycle(1, r2, 0, '0, 1, 0);
    checks++;
    if (o_count !== 5'd16 || q[$] !== r2) begin
      errors++; $display("FAIL full_requeue_read got c=%0d want 16", o_count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (o_cmd !== q[0]) begin
        errors++; $display("FAIL full_drain%0d got %h want %h", i, o_cmd, q[0]);
      end
      if (i == DEPTH - 1) begin
        checks++;
        if (o_cmd !== r2) begin
          errors++; $display("FAIL full_tail got %h want %h", o_cmd, r2);
        end
      end
      cycle(0, '0, 0, '0, 1, 0);
    end
    cycle(0, '0, 0, '0, 0, 1);
  endtask

  task automatic test_wrap();
    int pushed = 0, popped = 0, cyc = 0;
    bit w, hw, rd;
    while (popped < 40 && cyc < 2000) begin
      hw = pushed < 40 && ($urandom_range(0, 3) != 0);
      w  = hw && ($urandom_range(0, 7) == 0);
      rd = q.size() != 0 && ($urandom_range(0, 2) != 0);
      if (q.size() >= DEPTH - 1 && !rd) hw = 0;
      if (!hw) w = 0;
      if (rd) begin
        checks++;
        if (o_cmd !== q[0] || o_valid !== 1'b1) begin
          errors++; $display("FAIL wrap_data got %h want %h", o_cmd, q[0]);
        end
        popped++;
      end
      if (hw && (w || q.size() < DEPTH || rd)) pushed++;
      cycle(w, rnd_word(), hw && !w, rnd_word(), rd, 0);
      checks++;
      if (o_count !== 5'(q.size()) || o_count > 5'd16) begin
        errors++; $display("FAIL wrap_count got %0d want %0d", o_count, q.size());
      end
      cyc++;
    end
    checks++;
    if (popped != 40) begin
      errors++; $display("FAIL wrap_timeout got %0d pops want 40", popped);
    end
  endtask

  task automatic test_underflow_flush();
    logic [CMD_W-1:0] x;
    cycle(0, '0, 0, '0, 1, 0);
    checks++;
    if (o_underflow !== 1'b1 || o_count !== 5'd0) begin
      errors++; $display("FAIL unf_set got un=%0b c=%0d want 1 0", o_underflow, o_count);
    end
    for (int i = 0; i < 5; i++) cycle(0, '0, 1, rnd_word(), 0, 0);
    cycle(0, '0, 1, rnd_word(), 1, 1);
    checks++;
    if (o_underflow !== 1'b0 || o_count !== 5'd0 || o_valid !== 1'b0) begin
      errors++; $display("FAIL flush got un=%0b c=%0d v=%0b want 0 0 0", o_underflow, o_count, o_valid);
    end
    x = rnd_word();
    cycle(0, '0, 1, x, 1, 0);
    checks++;
    if (o_underflow !== 1'b1 || o_count !== 5'd1 || o_cmd !== x) begin
      errors++; $display("FAIL empty_rw got un=%0b c=%0d cmd=%h want 1 1 %h", o_underflow, o_count, o_cmd, x);
    end
    cycle(0, '0, 0, '0, 0, 1);
  endtask

  task automatic test_reset_midstream();
    logic [CMD_W-1:0] h;
    for (int i = 0; i < 7; i++) cycle(0, '0, 1, rnd_word(), 0, 0);
    i_read = 1;
    #2 i_rst = 1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_count !== 5'd0) begin
      errors++; $display("FAIL rst_mid got v=%0b c=%0d want 0 0", o_valid, o_count);
    end
    q.delete(); m_ovf = 0; m_unf = 0;
    @(negedge i_clk);
    i_read = 0;
    i_rst = 0;
    h = rnd_word();
    cycle(0, '0, 1, h, 0, 0);
    checks++;
    if (o_cmd !== h || o_count !== 5'd1 || o_underflow !== 1'b0) begin
      errors++; $display("FAIL rst_first got cmd=%h c=%0d un=%0b want %h 1 0", o_cmd, o_count, o_underflow, h);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_requeue_priority();
    test_full();
    test_wrap();
    test_underflow_flush();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
